// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage with data-cache handshake and MEM/WB register
//
// Ports:
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   *_i4                     EX/MEM register outputs (load/store request, address/ALU
//                            result, store data, write-back select, LUI, NPC, reg write,
//                            destination, halt)
//   dhit, dmemload           data cache completion and load data (valid with dhit)
//   dmemREN/WEN/addr/store   combinational data cache request
//   mem_stall                holds PC and upstream pipeline registers
//   wen_o5/wsel_o5/wdat_o5   MEM/WB register outputs
//   halt_o5                  sticky halt
//   mem_wait_cnt             saturating count of stall cycles since reset
module mem_stage #(
    parameter int WAITCNT_W = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 d_ren_i4,
    input  logic                 d_wen_i4,
    input  logic [31:0]          dmemaddr_i4,
    input  logic [31:0]          dmemstore_i4,
    input  logic [1:0]           W_mux_i4,
    input  logic [31:0]          LUI_i4,
    input  logic [31:0]          npc_i4,
    input  logic                 wen_i4,
    input  logic [4:0]           wsel_i4,
    input  logic                 halt_i4,
    input  logic                 dhit,
    input  logic [31:0]          dmemload,
    output logic                 dmemREN,
    output logic                 dmemWEN,
    output logic [31:0]          dmemaddr,
    output logic [31:0]          dmemstore,
    output logic                 mem_stall,
    output logic                 wen_o5,
    output logic [4:0]           wsel_o5,
    output logic [31:0]          wdat_o5,
    output logic                 halt_o5,
    output logic [WAITCNT_W-1:0] mem_wait_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic                   halted_q, halted_d;
    logic                   wen_q, wen_d;
    logic [4:0]             wsel_q, wsel_d;
    logic [31:0]            wdat_q, wdat_d;
    logic [WAITCNT_W-1:0]   cnt_q, cnt_d;

    logic                   memop;
    logic                   req;
    logic [31:0]            wb_mux;

    // Request generation and next-state logic
    always_comb begin
        memop     = (d_ren_i4 | d_wen_i4) & ~halted_q;
        // WAIT keeps the request up on its own; the upstream inputs are frozen
        // by the stall so the request fields stay consistent. Reset abandons it.
        req       = ~RST & ((state_q == WAIT) | memop);
        dmemWEN   = req & d_wen_i4;
        dmemREN   = req & d_ren_i4 & ~d_wen_i4;
        dmemaddr  = req ? dmemaddr_i4  : 32'h0;
        dmemstore = req ? dmemstore_i4 : 32'h0;
        mem_stall = req & ~dhit;

        state_d = state_q;
        case (state_q)
            IDLE: if (req && !dhit) state_d = WAIT;
            WAIT: if (!req || dhit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write-back select
    always_comb begin
        wb_mux = dmemaddr_i4;
        case (W_mux_i4)
            2'd0: wb_mux = dmemaddr_i4;
            2'd1: wb_mux = dmemload;
            2'd2: wb_mux = LUI_i4;
            2'd3: wb_mux = npc_i4;
            default: wb_mux = dmemaddr_i4;
        endcase
    end

    // MEM/WB register, halt flag and wait counter next values
    always_comb begin
        halted_d = halted_q;
        cnt_d    = cnt_q;
        wen_d    = 1'b0;
        wsel_d   = 5'd0;
        wdat_d   = 32'h0;

        if (mem_stall) begin
            // Bubble while waiting: the stalled instruction retires once, on its hit cycle
            if (cnt_q != {WAITCNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            wen_d  = wen_i4 & ~halted_q;
            wsel_d = wsel_i4;
            wdat_d = wb_mux;
            if (halt_i4) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            halted_q <= 1'b0;
            cnt_q    <= '0;
            wen_q    <= 1'b0;
            wsel_q   <= 5'd0;
            wdat_q   <= 32'h0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
            wen_q    <= wen_d;
            wsel_q   <= wsel_d;
            wdat_q   <= wdat_d;
        end
    end

    assign wen_o5       = wen_q;
    assign wsel_o5      = wsel_q;
    assign wdat_o5      = wdat_q;
    assign halt_o5      = halted_q;
    assign mem_wait_cnt = cnt_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard testbench for mem_stage
module tb_mem_stage;

    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          d_ren_i4, d_wen_i4;
    logic [31:0]   dmemaddr_i4, dmemstore_i4, LUI_i4, npc_i4, dmemload;
    logic [1:0]    W_mux_i4;
    logic          wen_i4, halt_i4, dhit;
    logic [4:0]    wsel_i4;
    logic          dmemREN, dmemWEN, mem_stall, wen_o5, halt_o5;
    logic [31:0]   dmemaddr, dmemstore, wdat_o5;
    logic [4:0]    wsel_o5;
    logic [CW-1:0] mem_wait_cnt;

    mem_stage #(.WAITCNT_W(CW)) dut (
        .CLK(CLK), .RST(RST),
        .d_ren_i4(d_ren_i4), .d_wen_i4(d_wen_i4),
        .dmemaddr_i4(dmemaddr_i4), .dmemstore_i4(dmemstore_i4),
        .W_mux_i4(W_mux_i4), .LUI_i4(LUI_i4), .npc_i4(npc_i4),
        .wen_i4(wen_i4), .wsel_i4(wsel_i4), .halt_i4(halt_i4),
        .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall),
        .wen_o5(wen_o5), .wsel_o5(wsel_o5), .wdat_o5(wdat_o5),
        .halt_o5(halt_o5), .mem_wait_cnt(mem_wait_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ren, wen, we, halt;
        logic [31:0] addr, st, lui, npc;
        logic [1:0]  wm;
        logic [4:0]  wsel;
    } instr_t;

    typedef struct {
        logic          wen;
        logic [4:0]    wsel;
        logic [31:0]   wdat;
        logic          halt;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;

    // Reference model state
    logic          m_halted = 1'b0;
    logic [CW-1:0] m_cnt    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: drive inputs, check combinational request, queue the MEM/WB result
    task automatic step(input instr_t in, input logic rst, input logic hit, input logic [31:0] ld);
        exp_t          e;
        logic          memop, stall;
        logic [31:0]   sel;
        memop = (in.ren || in.wen) && !m_halted && !rst;
        stall = memop && !hit;
        case (in.wm)
            2'd0:    sel = in.addr;
            2'd1:    sel = ld;
            2'd2:    sel = in.lui;
            default: sel = in.npc;
        endcase
        e = '{wen: 1'b0, wsel: 5'd0, wdat: 32'h0, halt: 1'b0, cnt: '0};
        if (rst) begin
            m_halted = 1'b0;
            m_cnt    = '0;
        end else if (stall) begin
            if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
        end else begin
            e.wen  = in.we && !m_halted;
            e.wsel = in.wsel;
            e.wdat = sel;
            if (in.halt) m_halted = 1'b1;
        end
        e.halt = m_halted;
        e.cnt  = m_cnt;

        @(negedge CLK);
        RST = rst;
        d_ren_i4 = in.ren; d_wen_i4 = in.wen; dmemaddr_i4 = in.addr; dmemstore_i4 = in.st;
        W_mux_i4 = in.wm; LUI_i4 = in.lui; npc_i4 = in.npc; wen_i4 = in.we;
        wsel_i4 = in.wsel; halt_i4 = in.halt; dhit = hit; dmemload = ld;
        #1;
        chk("dmemREN",   {31'd0, dmemREN},   {31'd0, memop && in.ren && !in.wen});
        chk("dmemWEN",   {31'd0, dmemWEN},   {31'd0, memop && in.wen});
        chk("mem_stall", {31'd0, mem_stall}, {31'd0, stall});
        if (!rst) begin
            chk("dmemaddr",  dmemaddr,  memop ? in.addr : 32'h0);
            chk("dmemstore", dmemstore, memop ? in.st   : 32'h0);
        end
        exp_q.push_back(e);
    endtask

    // Whole instruction: memory ops wait n cycles before the hit
    task automatic run_instr(input instr_t in, input int n, input logic [31:0] ld);
        if ((in.ren || in.wen) && !m_halted) begin
            for (int k = 0; k <= n; k++)
                step(in, 1'b0, k == n, (k == n) ? ld : $urandom);
        end else begin
            step(in, 1'b0, 1'($urandom_range(0, 1)), ld);
        end
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        i.ren  = ($urandom_range(0, 9) < 3);
        i.wen  = ($urandom_range(0, 9) < 3);
        i.we   = 1'($urandom_range(0, 1));
        i.halt = 1'b0;
        i.addr = $urandom; i.st = $urandom; i.lui = $urandom; i.npc = $urandom;
        i.wm   = 2'($urandom_range(0, 3));
        i.wsel = 5'($urandom_range(0, 31));
        return i;
    endfunction

    function automatic instr_t mk(input logic ren, wen, we, halt, input logic [1:0] wm,
                                  input logic [4:0] wsel, input logic [31:0] addr, st);
        instr_t i;
        i.ren = ren; i.wen = wen; i.we = we; i.halt = halt; i.wm = wm; i.wsel = wsel;
        i.addr = addr; i.st = st; i.lui = 32'h1234_0000; i.npc = 32'h0000_0404;
        return i;
    endfunction

    // Monitor: one MEM/WB result per clock edge
    initial begin
        forever begin
            exp_t e;
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wen_o5",       {31'd0, wen_o5},       {31'd0, e.wen});
                chk("wsel_o5",      {27'd0, wsel_o5},      {27'd0, e.wsel});
                chk("wdat_o5",      wdat_o5,               e.wdat);
                chk("halt_o5",      {31'd0, halt_o5},      {31'd0, e.halt});
                chk("mem_wait_cnt", {{(32-CW){1'b0}}, mem_wait_cnt}, {{(32-CW){1'b0}}, e.cnt});
            end
        end
    end

    initial begin
        instr_t nop, ld_i;
        RST = 1'b1; d_ren_i4 = 0; d_wen_i4 = 0; dmemaddr_i4 = 0; dmemstore_i4 = 0;
        W_mux_i4 = 0; LUI_i4 = 0; npc_i4 = 0; wen_i4 = 0; wsel_i4 = 0; halt_i4 = 0;
        dhit = 0; dmemload = 0;
        nop = mk(0, 0, 0, 0, 2'd0, 5'd0, 32'h0, 32'h0);

        step(nop, 1'b1, 1'b0, 32'h0);
        step(nop, 1'b1, 1'b0, 32'h0);

        // ALU op, load with three wait cycles, zero-wait store
        run_instr(mk(0, 0, 1, 0, 2'd0, 5'd5, 32'h10, 32'h0), 0, 32'h0);
        run_instr(mk(1, 0, 1, 0, 2'd1, 5'd7, 32'h100, 32'h0), 3, 32'hDEAD_BEEF);
        run_instr(mk(0, 1, 0, 0, 2'd0, 5'd0, 32'h200, 32'h55), 0, 32'h0);
        run_instr(mk(0, 0, 1, 0, 2'd2, 5'd9, 32'h0, 32'h0), 0, 32'h0);
        run_instr(mk(0, 0, 1, 0, 2'd3, 5'd31, 32'h0, 32'h0), 0, 32'h0);
        // Load and store together: store wins
        run_instr(mk(1, 1, 0, 0, 2'd0, 5'd0, 32'h300, 32'hA5A5), 1, 32'h0);

        // Reset in the middle of a pending load, then the load completes afresh
        ld_i = mk(1, 0, 1, 0, 2'd1, 5'd3, 32'h400, 32'h0);
        step(ld_i, 1'b0, 1'b0, 32'h0);
        step(ld_i, 1'b0, 1'b0, 32'h0);
        step(ld_i, 1'b1, 1'b0, 32'h0);
        step(ld_i, 1'b0, 1'b1, 32'hCAFE_F00D);

        // Randomized traffic; counter saturates along the way
        for (int n = 0; n < 200; n++)
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom);

        // Halt, then later memory ops are suppressed and write nothing
        run_instr(mk(0, 0, 1, 1, 2'd0, 5'd4, 32'h44, 32'h0), 0, 32'h0);
        run_instr(mk(1, 0, 1, 0, 2'd1, 5'd6, 32'h500, 32'h0), 2, 32'h1111_2222);
        for (int n = 0; n < 10; n++)
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom);

        @(posedge CLK);
        #2;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline. It sits directly downstream of the EX/MEM pipeline register and consumes its outputs. It issues load and store requests to the data cache and holds the pipeline with a stall while the cache has not answered. It selects the register write-back data and registers everything into the MEM/WB boundary consumed by the write-back stage.

## Interface
Parameters:
- WAITCNT_W, 16, width of the saturating memory-wait cycle counter

Ports:
- CLK  in  1  pipeline clock, rising edge
- RST  in  1  reset, synchronous, active-high
- d_ren_i4  in  1  load request, from EX/MEM register
- d_wen_i4  in  1  store request, from EX/MEM register
- dmemaddr_i4  in  32  ALU result; also the memory address
- dmemstore_i4  in  32  store data
- W_mux_i4  in  2  write-back select: 0 ALU, 1 LOAD, 2 LUI, 3 NPC
- LUI_i4  in  32  LUI result
- npc_i4  in  32  PC+4, the link value for JAL
- wen_i4  in  1  register-file write enable
- wsel_i4  in  5  destination register
- halt_i4  in  1  halt instruction in this stage
- dhit  in  1  data cache done; load data is valid in the same cycle
- dmemload  in  32  load data from the cache
- dmemREN  out  1  cache read request
- dmemWEN  out  1  cache write request
- dmemaddr  out  32  cache address
- dmemstore  out  32  cache store data
- mem_stall  out  1  stalls the PC and IF/ID, ID/EX and EX/MEM registers (their enable is 0)
- wen_o5  out  1  MEM/WB register-write enable
- wsel_o5  out  5  MEM/WB destination register
- wdat_o5  out  32  MEM/WB write-back data
- halt_o5  out  1  sticky halt to the datapath
- mem_wait_cnt  out  WAITCNT_W  total stall cycles since reset, saturating

## Operation
Memory operation:
- memop = (d_ren_i4 | d_wen_i4) & ~halted.
- If both d_ren_i4 and d_wen_i4 are set, the store wins: WEN=1, REN=0.

FSM states: IDLE and WAIT.
- IDLE, memop=0: no request; the MEM/WB register loads normally.
- IDLE, memop=1: drive the request combinationally.
  - dhit=1 in the same cycle: zero-wait access. mem_stall=0, the MEM/WB register loads, stay in IDLE.
  - dhit=0: mem_stall=1, next state WAIT.
- WAIT: hold the request and mem_stall=1 until dhit.
  - On dhit: mem_stall=0, the MEM/WB register loads with dmemload where selected, next state IDLE.
- Request outputs during a request: dmemaddr=dmemaddr_i4 and dmemstore=dmemstore_i4.
- Request outputs when idle: dmemaddr=0 and dmemstore=0.
- When mem_stall=1, the upstream stages hold their registers, so all *_i4 inputs are stable.

Write-back data, 32-bit mux on W_mux_i4:
- 0: dmemaddr_i4
- 1: dmemload
- 2: LUI_i4
- 3: npc_i4

MEM/WB register:
- In a cycle with mem_stall=1 it loads a bubble: wen_o5=0, wsel_o5=0, wdat_o5=0. The stalled instruction is then written exactly once, on its completion cycle.
- Otherwise it loads wen_i4, wsel_i4 and the mux output.

Halt:
- halt_i4=1 while mem_stall=0 sets halted at the next edge. halt_o5=halted.
- halted stays 1 until RST.
- While halted: memop is forced 0 and wen_o5 loads 0.

Wait counter:
- Increments on every cycle with mem_stall=1.
- Saturates at all ones.

Reset, RST=1 at a rising edge:
- state=IDLE, halted=0, counter=0.
- wen_o5=0, wsel_o5=0, wdat_o5=0, halt_o5=0.
- While RST=1, dmemREN, dmemWEN and mem_stall are forced 0, including when the FSM is in WAIT (reset mid-access abandons the request).

## Timing
- Combinational outputs:
  - dmemREN, dmemWEN, dmemaddr and dmemstore are combinational from the state and the *_i4 inputs.
  - mem_stall is combinational from the state, the inputs and dhit.
- All other outputs are registered.
- Latency, non-memory instruction: 1 cycle from EX/MEM output to MEM/WB output.
- Latency, memory instruction: 1 + N cycles, where N is the number of cycles with dhit=0 before the hit.
- Stall duration: mem_stall is high for exactly N cycles.
- dhit arriving while no request is asserted is ignored.
- After dhit the next instruction is presented in the following cycle. It may issue immediately, so back-to-back requests are allowed.

## Test plan
- Reset, then RST=0: all registered outputs are 0, dmemREN=dmemWEN=0 and mem_stall=0.
- ALU op with W_mux=0, dmemaddr_i4=0x10, wen=1, wsel=5 -> next edge: wen_o5=1, wsel_o5=5, wdat_o5=0x10, no stall.
- Load from 0x100, dhit held low 3 cycles, then dmemload=0xDEADBEEF with dhit:
  - dmemREN=1 for 4 cycles and mem_stall=1 for 3 cycles.
  - MEM/WB shows 3 bubbles, then wdat_o5=0xDEADBEEF.
  - mem_wait_cnt=3.
- Store of 0x55 to 0x200 with dhit in the same cycle -> dmemWEN=1 for 1 cycle, mem_stall stays 0, wen_o5=0.
- Load pending in WAIT, RST asserted -> dmemREN=0 and mem_stall=0 while RST=1; the FSM is in IDLE after the edge.
- halt_i4=1 -> halt_o5=1 at the next edge and stays 1. A later load presents no dmemREN and gives wen_o5=0.
